serial_receiver: RTL

Serial-to-parallel receive stage that sits directly downstream of the transmitter and consumes its serial output. It frames the single-bit stream (start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit), reassembles the parallel word, and presents it on a valid/ready handshake to the parallel consumer. It runs entirely in the serial clock domain, one bit per clock, with no oversampling.

---
 rtl/serial_receiver.sv | 126 ++++++++++++
 1 files changed

// File: rtl/serial_receiver.sv
// Serial-to-parallel receive stage: start bit, DATA_WIDTH data bits LSB first, optional even parity, stop bit.
// Optional feature macro: RX_PARITY_EN adds the parity bit, the PARITY state and rx_parity_err_o.
module serial_receiver #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rx_sclk_i,
  input  logic                  rx_srst_i,
  input  logic                  rx_sdata_i,
  input  logic                  rx_pready_i,
  output logic [DATA_WIDTH-1:0] rx_pdata_o,
  output logic                  rx_pdata_valid_o,
  output logic                  rx_busy_o,
  output logic                  rx_frame_err_o,
  output logic                  rx_overrun_o,
  output logic                  rx_parity_err_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
`ifdef RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] shift_reg;

`ifdef RX_PARITY_EN
  logic parity_bad;
`endif

  assign rx_busy_o = (state != S_IDLE);

  always_ff @(posedge rx_sclk_i or posedge rx_srst_i) begin
    if (rx_srst_i) begin
      state            <= S_IDLE;
      cnt              <= '0;
      shift_reg        <= '0;
      rx_pdata_o       <= '0;
      rx_pdata_valid_o <= 1'b0;
      rx_frame_err_o   <= 1'b0;
      rx_overrun_o     <= 1'b0;
`ifdef RX_PARITY_EN
      rx_parity_err_o  <= 1'b0;
      parity_bad       <= 1'b0;
`endif
    end else begin
      rx_frame_err_o <= 1'b0;
      rx_overrun_o   <= 1'b0;
`ifdef RX_PARITY_EN
      rx_parity_err_o <= 1'b0;
`endif
      // NOTE: non-blocking, so a load in S_STOP below overrides this accept-clear on the same edge.
      if (rx_pdata_valid_o && rx_pready_i)
        rx_pdata_valid_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_sdata_i) begin
            state <= S_DATA;
            cnt   <= '0;
          end
        end

        S_DATA: begin
          shift_reg[cnt] <= rx_sdata_i;
          if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
            cnt <= '0;
`ifdef RX_PARITY_EN
            state <= S_PARITY;
`else
            state <= S_STOP;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

`ifdef RX_PARITY_EN
        S_PARITY: begin
          // Even parity: the parity bit must equal the XOR of the data bits.
          parity_bad <= (rx_sdata_i != ^shift_reg);
          state      <= S_STOP;
        end
`endif

        S_STOP: begin
          if (rx_sdata_i) begin
            if (!rx_pdata_valid_o || rx_pready_i) begin
              rx_pdata_o       <= shift_reg;
              rx_pdata_valid_o <= 1'b1;
            end else begin
              rx_overrun_o <= 1'b1;
            end
`ifdef RX_PARITY_EN
            rx_parity_err_o <= parity_bad;
`endif
            state <= S_IDLE;
          end else begin
            // Bad stop bit: drop the frame and wait out a break before hunting for a start bit.
            rx_frame_err_o <= 1'b1;
            state          <= S_WAIT_IDLE;
          end
        end

        S_WAIT_IDLE: begin
          if (rx_sdata_i)
            state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef RX_PARITY_EN
  assign rx_parity_err_o = 1'b0;
`endif

endmodule
